// File: rtl/rs232_tx_fifo.sv
// rs232_tx_fifo: 4-entry byte FIFO feeding an 8N1/8N2 serialiser with back-to-back frames.
module rs232_tx_fifo #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       txd_out,
  output logic       busy_out,
  output logic [2:0] level_out
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  state_t      state_q, state_d;
  logic [7:0]  mem_q [4];
  logic [7:0]  mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  level_q, level_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        wr, pop, bit_end;
  assign ready_out = ~level_q[2];
  assign txd_out   = txd_q;
  assign busy_out  = state_q != IDLE;
  assign level_out = level_q;
  always_comb begin
    wr       = valid_in && ready_out;
    pop      = 1'b0;
    bit_end  = timer_q == BIT_LAST;
    state_d  = state_q;
    timer_d  = timer_q + 16'd1;
    idx_d    = idx_q;
    mem_d    = mem_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (level_q != 3'd0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
        timer_d = '0;
      end
      DATA: if (bit_end) begin
        timer_d = '0;
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (bit_end) begin
        timer_d = '0;
        idx_d   = idx_q + 3'd1;
        // idx doubles as the stop-bit counter so the timer only spans one bit
        if (idx_q == STOP_LAST) begin
          idx_d   = '0;
          pop     = level_q != 3'd0;
          state_d = pop ? START : IDLE;
        end
      end
    endcase
    if (wr) mem_d[wr_ptr_q] = data_in;
    shift_d  = pop ? mem_q[rd_ptr_q] : shift_q;
    wr_ptr_d = wr_ptr_q + 2'(wr);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    level_d  = level_q + 3'(wr) - 3'(pop);
    txd_d    = state_d == START ? 1'b0 : state_d == DATA ? shift_d[idx_d] : 1'b1;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end
endmodule

// File: doc/rs232_tx_fifo.md
RS232_TX_FIFO -- requirements
Module: rs232_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1: clock cycles per serial bit; legal range 1..65535.
REQ-002 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-003 Port clk_in, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst_in, input, 1: reset, asynchronous, active-high.
REQ-005 Port data_in, input, 8: byte offered for transmission.
REQ-006 Port valid_in, input, 1: data_in is valid this cycle.
REQ-007 Port ready_out, output, 1: FIFO can accept a byte this cycle.
REQ-008 Port txd_out, output, 1: serial line driven to the downstream rs232 receiver's rxd_in; idle high.
REQ-009 Port busy_out, output, 1: serialiser is mid-frame (state not IDLE).
REQ-010 Port level_out, output, 3: number of bytes held in the FIFO, 0..4.

Function
REQ-011 The block SHALL contain a 4-entry byte FIFO with 2-bit read/write pointers that wrap modulo 4.
REQ-012 A write SHALL occur on a rising edge where valid_in=1 and ready_out=1; data_in is stored at the write pointer.
REQ-013 ready_out SHALL equal (level_out < 4), registered-state derived; when full, a write is refused even if a pop occurs in the same cycle.
REQ-014 valid_in while ready_out=0 SHALL be ignored, with no state change.
REQ-015 A simultaneous write and pop SHALL leave level_out unchanged and advance both pointers.
REQ-016 The serialiser SHALL use states IDLE, START, DATA, STOP, with a 16-bit bit timer and a 3-bit data bit index.
REQ-017 IDLE: txd_out=1; if level_out>0, pop the FIFO head into an 8-bit shift register, go to START, and clear the timer.
REQ-018 START: txd_out=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-019 DATA: txd_out = shift bit [index], LSB first, each bit held for CLKS_PER_BIT cycles; after index 7 completes, go to STOP.
REQ-020 STOP: txd_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-021 At the end of STOP, if level_out>0, pop the FIFO and go directly to START, with zero idle cycles between frames; otherwise go to IDLE.
REQ-022 txd_out SHALL be a registered output and SHALL be glitch-free.
REQ-023 Latency: a byte written at edge N into an empty FIFO with state IDLE SHALL pop at edge N+1, where txd_out falls to 0.
REQ-024 Frame length SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-025 The byte SHALL be captured at pop; later FIFO writes SHALL NOT alter a frame in progress.
REQ-026 busy_out SHALL be 1 in START, DATA and STOP, and 0 in IDLE.

Reset
REQ-027 While rst_in=1, asynchronously:
- txd_out=1, ready_out=1, busy_out=0, level_out=0
- pointers, timer and index cleared; state IDLE.
REQ-028 Reset asserted mid-frame SHALL abandon the frame and flush the FIFO; the line returns high immediately with no partial stop bit.
REQ-029 After rst_in deasserts, the first write SHALL be accepted on the next rising edge.

Verification
REQ-030 CLKS_PER_BIT=1, STOP_BITS=1; write 0xA5 once -> txd_out sequence from edge N+1: 0,1,0,1,0,0,1,0,1,1, then idle 1; busy_out high for 10 cycles.
REQ-031 Write 0x01,0x02,0x03,0x04,0x05 in consecutive cycles -> 0x01 pops at once, 0x02..0x05 are accepted (level_out peaks at 4), nothing is refused; then five back-to-back 10-cycle frames with no idle gap.
REQ-032 Fill the FIFO to 4 during a frame with valid_in held high -> ready_out=0 and data_in is not stored; the write is accepted in the cycle after the pop makes level_out=3.
REQ-033 CLKS_PER_BIT=16, STOP_BITS=2; send 0x3C -> start low 16 cycles, each data bit 16 cycles (0,0,1,1,1,1,0,0), stop high 32 cycles; total 176 cycles.
REQ-034 Assert rst_in during DATA bit 4 with 2 bytes queued -> txd_out=1 and level_out=0 immediately, no further frames; a fresh 0x55 after release transmits correctly.
REQ-035 Loopback: txd_out connected to the rs232 block's rxd_in with CLKS_PER_BIT=1; send 0x5A -> the downstream block echoes frame 0,0,1,0,1,1,0,1,0,1.
